// File: rtl/pds_cycle_sequencer_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pds_cycle_sequencer_pkg
// Brief    : State encodings and E-clock timing constants for the PDS sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package pds_cycle_sequencer_pkg;

   localparam int                 E_CNT_W      = 4;
   localparam logic [E_CNT_W-1:0] E_PERIOD     = 4'd10;
   localparam logic [E_CNT_W-1:0] E_HIGH_START = 4'd6;
   localparam logic [E_CNT_W-1:0] VMA_COUNT    = 4'd2;
   localparam logic [E_CNT_W-1:0] VMA_END      = 4'd9;

   typedef enum logic [1:0] {
      OWN_RESET = 2'd0,
      OWN_REQ   = 2'd1,
      OWNED     = 2'd2
   } own_state_t;

   typedef enum logic [2:0] {
      CYC_IDLE   = 3'd0,
      CYC_SYNC   = 3'd1,
      CYC_ASSERT = 3'd2,
      CYC_WAIT   = 3'd3,
      CYC_VMA    = 3'd4,
      CYC_DONE   = 3'd5,
      CYC_ERR    = 3'd6
   } cyc_state_t;

endpackage
`default_nettype wire

// File: rtl/pds_eclock_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pds_eclock_gen
// Brief    : Free-running 6800 E clock divider and PMCYC phase tracker.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pds_eclock_gen
   import pds_cycle_sequencer_pkg::*;
(
   input  logic               pdsC8M,
   input  logic               pdsRESETn,
   input  logic               pdsPMCYCn,
   output logic [E_CNT_W-1:0] eCount,
   output logic [1:0]         cycPhase,
   output logic               pdsClockE
);

   logic [E_CNT_W-1:0] r_e_count;
   logic [1:0]         r_cyc_phase;

   always_ff @(posedge pdsC8M) begin
      if (!pdsRESETn) begin
         r_e_count   <= '0;
         r_cyc_phase <= 2'd0;
      end else begin
         r_e_count   <= (r_e_count == E_PERIOD - E_CNT_W'(1)) ? '0 : r_e_count + E_CNT_W'(1);
         r_cyc_phase <= pdsPMCYCn ? 2'd0 : r_cyc_phase + 2'd1;
      end
   end

   // E is low for the first six counts of each period and high for the last four.
   assign pdsClockE = (r_e_count >= E_HIGH_START);
   assign eCount    = r_e_count;
   assign cycPhase  = r_cyc_phase;

endmodule
`default_nettype wire

// File: rtl/pds_cycle_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : pds_cycle_sequencer
// Brief    : Runs 68030-side requests as Mac SE PDS 68000-style bus cycles.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module pds_cycle_sequencer
   import pds_cycle_sequencer_pkg::*;
#(
   parameter int TO_WIDTH       = 8,
   parameter int TIMEOUT_CYCLES = 200,
   parameter int PMCYC_SLOT     = 1
) (
   input  logic pdsC8M,
   input  logic pdsRESETn,
   input  logic reqValid,
   input  logic reqRnW,
   input  logic reqMem,
   input  logic reqIack,
   input  logic reqUpper,
   input  logic reqLower,
   input  logic pdsPMCYCn,
   input  logic pdsDTACKn,
   input  logic pdsVPAn,
   input  logic pdsBERRn,
   input  logic pdsBGn,
   output logic pdsASn,
   output logic pdsUDSn,
   output logic pdsLDSn,
   output logic pdsVMAn,
   output logic pdsClockE,
   output logic pdsDrive,
   output logic pdsBRn,
   output logic pdsBGACKn,
   output logic cpuHoldn,
   output logic busOwned,
   output logic reqDone,
   output logic reqAvec,
   output logic reqErr
);

   localparam logic [TO_WIDTH-1:0] c_to_limit   = TO_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [1:0]          c_pmcyc_slot = 2'(PMCYC_SLOT);

   logic [E_CNT_W-1:0] w_e_count;
   logic [1:0]         w_cyc_phase;

   own_state_t          r_own_state, w_own_next;
   logic                r_bg_seen;
   cyc_state_t          r_cyc_state, w_cyc_next;
   logic [TO_WIDTH-1:0] r_to_cnt;
   logic                r_vma_act;
   logic                r_req_done, r_req_avec, r_req_err;
   logic                w_done_pulse, w_avec_pulse, w_err_pulse;
   logic                w_owned, w_vma_assert, w_as_active, w_lanes;

   pds_eclock_gen u_eclock (
      .pdsC8M    (pdsC8M),
      .pdsRESETn (pdsRESETn),
      .pdsPMCYCn (pdsPMCYCn),
      .eCount    (w_e_count),
      .cycPhase  (w_cyc_phase),
      .pdsClockE (pdsClockE)
   );

   always_ff @(posedge pdsC8M) begin
      if (!pdsRESETn) begin
         r_own_state <= OWN_RESET;
         r_bg_seen   <= 1'b0;
      end else begin
         r_own_state <= w_own_next;
         r_bg_seen   <= (r_own_state == OWN_REQ) && !pdsBGn;
      end
   end

   // Grant must be seen on two consecutive clocks; once owned the bus is kept until reset.
   always_comb begin
      w_own_next = r_own_state;
      case (r_own_state)
         OWN_RESET: w_own_next = OWN_REQ;
         OWN_REQ:   if (!pdsBGn && r_bg_seen) w_own_next = OWNED;
         OWNED:     w_own_next = OWNED;
         default:   w_own_next = OWN_RESET;
      endcase
   end

   assign w_owned   = (r_own_state == OWNED);
   assign pdsBRn    = !((r_own_state == OWN_REQ) || w_owned);
   assign pdsBGACKn = !w_owned;
   assign pdsDrive  = w_owned;
   assign cpuHoldn  = w_owned;
   assign busOwned  = w_owned;

   always_ff @(posedge pdsC8M) begin
      if (!pdsRESETn) begin
         r_cyc_state <= CYC_IDLE;
         r_to_cnt    <= '0;
         r_vma_act   <= 1'b0;
         r_req_done  <= 1'b0;
         r_req_avec  <= 1'b0;
         r_req_err   <= 1'b0;
      end else begin
         r_cyc_state <= w_cyc_next;
         // Counts WAIT clocks including the one in progress.
         if (r_cyc_state == CYC_IDLE)
            r_to_cnt <= '0;
         else if ((w_cyc_next == CYC_WAIT) && (r_to_cnt != '1))
            r_to_cnt <= r_to_cnt + 1'b1;
         r_vma_act  <= (w_cyc_next == CYC_VMA) && w_vma_assert;
         r_req_done <= w_done_pulse;
         r_req_avec <= w_avec_pulse;
         r_req_err  <= w_err_pulse;
      end
   end

   always_comb begin
      w_cyc_next   = r_cyc_state;
      w_done_pulse = 1'b0;
      w_avec_pulse = 1'b0;
      w_err_pulse  = 1'b0;
      case (r_cyc_state)
         CYC_IDLE:
            if (w_owned && reqValid) w_cyc_next = reqMem ? CYC_SYNC : CYC_ASSERT;
         CYC_SYNC:
            if (!reqValid)                                         w_cyc_next = CYC_IDLE;
            else if (!pdsPMCYCn && (w_cyc_phase != c_pmcyc_slot)) w_cyc_next = CYC_ASSERT;
         CYC_ASSERT:
            w_cyc_next = reqValid ? CYC_WAIT : CYC_IDLE;
         CYC_WAIT:
            if (!reqValid) w_cyc_next = CYC_IDLE;
            else if (!pdsBERRn) begin
               w_cyc_next  = CYC_ERR;
               w_err_pulse = 1'b1;
            end else if (!pdsDTACKn) begin
               w_cyc_next   = CYC_DONE;
               w_done_pulse = 1'b1;
            end else if (!pdsVPAn) w_cyc_next = CYC_VMA;
            else if (r_to_cnt == c_to_limit) begin
               w_cyc_next  = CYC_ERR;
               w_err_pulse = 1'b1;
            end
         CYC_VMA:
            if (!reqValid) w_cyc_next = CYC_IDLE;
            else if (w_vma_assert && (w_e_count == VMA_END)) begin
               w_cyc_next   = CYC_DONE;
               w_avec_pulse = reqIack;
               w_done_pulse = !reqIack;
            end
         CYC_DONE, CYC_ERR:
            if (!reqValid) w_cyc_next = CYC_IDLE;
         default: w_cyc_next = CYC_IDLE;
      endcase
   end

   // VMA only starts on eCount==2, so entry late in a period waits for the next one.
   assign w_vma_assert = (r_cyc_state == CYC_VMA) && (r_vma_act || (w_e_count == VMA_COUNT));
   assign w_as_active  = (r_cyc_state == CYC_ASSERT) || (r_cyc_state == CYC_WAIT) ||
                         (r_cyc_state == CYC_VMA);
   assign w_lanes      = ((r_cyc_state == CYC_ASSERT) && reqRnW) ||
                         (r_cyc_state == CYC_WAIT) || (r_cyc_state == CYC_VMA);

   assign pdsASn  = !w_as_active;
   assign pdsUDSn = !(w_lanes && reqUpper);
   assign pdsLDSn = !(w_lanes && reqLower);
   assign pdsVMAn = !w_vma_assert;
   assign reqDone = r_req_done;
   assign reqAvec = r_req_avec;
   assign reqErr  = r_req_err;

endmodule
`default_nettype wire

// File: tb/tb_pds_cycle_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_pds_cycle_sequencer
// Brief    : Directed bench with a termination scoreboard for pds_cycle_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pds_cycle_sequencer;

   localparam logic [2:0] c_k_done = 3'b100;
   localparam logic [2:0] c_k_avec = 3'b010;
   localparam logic [2:0] c_k_err  = 3'b001;

   typedef struct {
      logic [2:0] kind;
      int         edge_n;
   } sb_item_t;

   logic clk = 1'b0;
   logic pdsRESETn, reqValid, reqRnW, reqMem, reqIack, reqUpper, reqLower;
   logic pdsPMCYCn, pdsDTACKn, pdsVPAn, pdsBERRn, pdsBGn;
   logic pdsASn, pdsUDSn, pdsLDSn, pdsVMAn, pdsClockE, pdsDrive, pdsBRn, pdsBGACKn;
   logic cpuHoldn, busOwned, reqDone, reqAvec, reqErr;

   int       vectors = 0;
   int       miscompares = 0;
   int       edge_cnt = 0;
   int       rel_base = 0;
   sb_item_t sb_q[$];
   sb_item_t mon_item;

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   pds_cycle_sequencer #(
      .TO_WIDTH       (8),
      .TIMEOUT_CYCLES (16),
      .PMCYC_SLOT     (1)
   ) dut (
      .pdsC8M    (clk),
      .pdsRESETn (pdsRESETn),
      .reqValid  (reqValid),
      .reqRnW    (reqRnW),
      .reqMem    (reqMem),
      .reqIack   (reqIack),
      .reqUpper  (reqUpper),
      .reqLower  (reqLower),
      .pdsPMCYCn (pdsPMCYCn),
      .pdsDTACKn (pdsDTACKn),
      .pdsVPAn   (pdsVPAn),
      .pdsBERRn  (pdsBERRn),
      .pdsBGn    (pdsBGn),
      .pdsASn    (pdsASn),
      .pdsUDSn   (pdsUDSn),
      .pdsLDSn   (pdsLDSn),
      .pdsVMAn   (pdsVMAn),
      .pdsClockE (pdsClockE),
      .pdsDrive  (pdsDrive),
      .pdsBRn    (pdsBRn),
      .pdsBGACKn (pdsBGACKn),
      .cpuHoldn  (cpuHoldn),
      .busOwned  (busOwned),
      .reqDone   (reqDone),
      .reqAvec   (reqAvec),
      .reqErr    (reqErr)
   );

   // Termination monitor: every pulse must match the next expected kind and edge.
   always @(negedge clk) begin
      if (pdsRESETn && (reqDone || reqAvec || reqErr)) begin
         vectors = vectors + 1;
         if (sb_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL term_unexpected: got kind=%b at edge %0d, required none",
                     {reqDone, reqAvec, reqErr}, edge_cnt);
         end else begin
            mon_item = sb_q.pop_front();
            if (({reqDone, reqAvec, reqErr} !== mon_item.kind) || (edge_cnt != mon_item.edge_n)) begin
               miscompares = miscompares + 1;
               $display("FAIL term: got kind=%b at edge %0d, required kind=%b at edge %0d",
                        {reqDone, reqAvec, reqErr}, edge_cnt, mon_item.kind, mon_item.edge_n);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors = vectors + 1;
      if (act !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_term(input logic [2:0] kind, input int edge_n);
      sb_q.push_back('{kind, edge_n});
   endtask

   function automatic int e_model();
      return (edge_cnt - rel_base) % 10;
   endfunction

   function automatic logic [15:0] rst_vec();
      return {3'b000, pdsASn, pdsUDSn, pdsLDSn, pdsVMAn, pdsClockE, pdsDrive, pdsBRn,
              pdsBGACKn, cpuHoldn, busOwned, reqDone, reqAvec, reqErr};
   endfunction

   task automatic run_vpa(input logic iack);
      reqIack  = iack;
      reqValid = 1'b1;
      step();
      step();
      for (int i = 0; i < 10 && e_model() != 5; i++) step();
      pdsVPAn = 1'b0;
      expect_term(iack ? c_k_avec : c_k_done, edge_cnt + 15);
      step();
      for (int k = 0; k < 14; k++) begin
         check("vpa_vma", 16'(pdsVMAn), (k < 6) ? 16'd1 : 16'd0);
         step();
      end
      check("vpa_release", 16'({pdsASn, pdsVMAn}), 16'b11);
      reqValid = 1'b0;
      pdsVPAn  = 1'b1;
      reqIack  = 1'b0;
      step();
   endtask

   initial begin
      pdsRESETn = 1'b0; reqValid = 1'b0; reqRnW = 1'b1; reqMem = 1'b0; reqIack = 1'b0;
      reqUpper = 1'b1; reqLower = 1'b1; pdsPMCYCn = 1'b1; pdsDTACKn = 1'b1;
      pdsVPAn = 1'b1; pdsBERRn = 1'b1; pdsBGn = 1'b1;
      repeat (3) step();
      check("reset_state", rst_vec(), 16'h1E60);

      // Ownership: a single-clock grant is ignored, two consecutive grants take the bus.
      pdsRESETn = 1'b1;
      rel_base  = edge_cnt;
      step();
      check("br_req", 16'(pdsBRn), 16'd0);
      pdsBGn = 1'b0; step();
      pdsBGn = 1'b1; step(); step();
      check("bg_glitch", 16'({busOwned, pdsBGACKn}), 16'b01);
      pdsBGn = 1'b0; step();
      check("own_early", 16'(busOwned), 16'd0);
      step();
      check("owned", 16'({pdsBGACKn, cpuHoldn, busOwned, pdsDrive, pdsBRn}), 16'b01110);
      pdsBGn = 1'b1; step();
      check("own_sticky", 16'(busOwned), 16'd1);

      for (int i = 0; i < 10; i++) begin
         check("eclk", 16'(pdsClockE), (e_model() >= 6) ? 16'd1 : 16'd0);
         step();
      end

      // ROM read with DTACK already asserted.
      pdsDTACKn = 1'b0;
      expect_term(c_k_done, edge_cnt + 3);
      reqValid = 1'b1;
      step();
      check("rom_assert", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b000);
      step();
      check("rom_wait", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b000);
      step();
      check("rom_done", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b111);
      reqValid = 1'b0; pdsDTACKn = 1'b1;
      step();

      // RAM upper-byte write starting in the forbidden PMCYC phase.
      pdsPMCYCn = 1'b0; reqMem = 1'b1; reqRnW = 1'b0; reqLower = 1'b0; reqValid = 1'b1;
      step();
      check("ram_sync0", 16'(pdsASn), 16'd1);
      step();
      check("ram_sync1", 16'(pdsASn), 16'd1);
      step();
      check("ram_assert", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b011);
      step();
      check("ram_wait", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b001);
      expect_term(c_k_done, edge_cnt + 1);
      pdsDTACKn = 1'b0;
      step();
      check("ram_done", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b111);
      reqValid = 1'b0; pdsDTACKn = 1'b1; pdsPMCYCn = 1'b1;
      reqMem = 1'b0; reqRnW = 1'b1; reqLower = 1'b1;
      step();

      run_vpa(1'b0);
      run_vpa(1'b1);

      // No response: error after sixteen WAIT clocks.
      expect_term(c_k_err, edge_cnt + 18);
      reqValid = 1'b1;
      repeat (17) step();
      check("to_pending", 16'({pdsASn, reqErr}), 16'b00);
      step();
      check("to_release", 16'(pdsASn), 16'd1);
      reqValid = 1'b0;
      step();

      // BERR outranks DTACK.
      pdsBERRn = 1'b0; pdsDTACKn = 1'b0;
      expect_term(c_k_err, edge_cnt + 3);
      reqValid = 1'b1;
      repeat (3) step();
      reqValid = 1'b0; pdsBERRn = 1'b1; pdsDTACKn = 1'b1;
      step();

      // Abort in WAIT.
      reqValid = 1'b1;
      repeat (3) step();
      check("abort_pre", 16'(pdsASn), 16'd0);
      reqValid = 1'b0;
      step();
      check("abort_strobes", 16'({pdsASn, pdsUDSn, pdsLDSn}), 16'b111);
      repeat (2) step();

      // Reset while in VMA.
      pdsVPAn = 1'b0; reqValid = 1'b1;
      repeat (3) step();
      for (int i = 0; i < 10 && e_model() != 4; i++) step();
      check("vma_pre_reset", 16'(pdsASn), 16'd0);
      pdsRESETn = 1'b0;
      step();
      check("reset_mid", rst_vec(), 16'h1E60);
      reqValid = 1'b0; pdsVPAn = 1'b1;
      repeat (2) step();

      vectors = vectors + 1;
      if (sb_q.size() != 0) begin
         miscompares = miscompares + 1;
         $display("FAIL sb_drain: got %0d terminations outstanding, required 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
